// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: hazard/branch/memory stall and flush control for an in-order pipeline
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_detected_i,
  input  logic        branch_taken_i,
  input  logic        mem_req_i,
  input  logic        sram_ready_i,
  output logic        freeze_pc_o,
  output logic        freeze_if_id_o,
  output logic        bubble_id_ex_o,
  output logic        flush_if_id_o,
  output logic        freeze_pipe_o,
  output logic        mem_timeout_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_count_o,
  output logic [7:0]  flush_count_o
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, TIMEOUT = 2'd2} state_e;
  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);
  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] stall_q;
  logic [7:0]  flush_q;
  logic        mto_q;
  logic        frz;
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    frz     = 1'b0;
    case (state_q)
      MEM_WAIT: begin
        if (sram_ready_i) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          frz = 1'b1;
          if (wait_q < TMO) wait_d = wait_q + 8'd1;
          else state_d = TIMEOUT;
        end
      end
      TIMEOUT: frz = 1'b1;
      // the unused encoding falls in here and recovers as RUN
      default: begin
        state_d = RUN;
        wait_d  = '0;
        if (mem_req_i && !sram_ready_i) begin
          frz     = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = 8'd1;
        end
      end
    endcase
  end
  assign freeze_pipe_o  = !rst && frz;
  assign flush_if_id_o  = !rst && !frz && branch_taken_i;
  assign bubble_id_ex_o = !rst && !frz && (branch_taken_i || hazard_detected_i);
  assign freeze_pc_o    = !rst && (frz || (!branch_taken_i && hazard_detected_i));
  assign freeze_if_id_o = freeze_pc_o;
  assign mem_timeout_o  = mto_q;
  assign state_o        = state_q;
  assign stall_count_o  = stall_q;
  assign flush_count_o  = flush_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
      mto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if ((freeze_pipe_o || freeze_pc_o) && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (flush_if_id_o && flush_q != 8'hFF) flush_q <= flush_q + 8'd1;
      mto_q <= mto_q || (state_d == TIMEOUT);
    end
  end
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed scoreboard bench for pipeline_stall_controller (MEM_TIMEOUT=4)
module tb_pipeline_stall_controller;
  logic clk = 1'b0, rst = 1'b0;
  logic haz = 1'b0, br = 1'b0, mreq = 1'b0, rdy = 1'b0;
  logic fpc, fifid, bub, flush, fpipe, mto;
  logic [1:0] st;
  logic [15:0] scnt;
  logic [7:0] fcnt;
  int checks = 0, errs = 0;
  logic [15:0] es = '0;
  logic [7:0] ef = '0;
  typedef struct packed {logic [5:0] ctl; logic [1:0] st; logic [15:0] sc; logic [7:0] fc;} exp_t;
  exp_t q[$];
  // control vector order: {freeze_pc, freeze_if_id, bubble, flush, freeze_pipe, mem_timeout}
  localparam logic [5:0] NONE = 6'b000000, HAZ = 6'b111000, BR = 6'b001100, FRZ = 6'b110010, TO = 6'b110011;
  pipeline_stall_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .hazard_detected_i(haz), .branch_taken_i(br), .mem_req_i(mreq), .sram_ready_i(rdy),
    .freeze_pc_o(fpc), .freeze_if_id_o(fifid), .bubble_id_ex_o(bub), .flush_if_id_o(flush),
    .freeze_pipe_o(fpipe), .mem_timeout_o(mto), .state_o(st),
    .stall_count_o(scnt), .flush_count_o(fcnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic h, b, m, r, input logic [5:0] ctl, input logic [1:0] s);
    exp_t e;
    haz = h; br = b; mreq = m; rdy = r;
    q.push_back('{ctl: ctl, st: s, sc: es, fc: ef});
    @(negedge clk);
    if (q.size() == 0) chk("queue_empty", 16'd1, 16'd0);
    else begin
      e = q.pop_front();
      chk("ctl", {10'd0, fpc, fifid, bub, flush, fpipe, mto}, {10'd0, e.ctl});
      chk("state", {14'd0, st}, {14'd0, e.st});
      chk("stall_count", scnt, e.sc);
      chk("flush_count", {8'd0, fcnt}, {8'd0, e.fc});
    end
    if ((ctl[5] || ctl[1]) && es != 16'hFFFF) es++;
    if (ctl[2] && ef != 8'hFF) ef++;
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; haz = 1'b1; br = 1'b1; mreq = 1'b1; rdy = 1'b0;
    #1;
    chk("rst_ctl", {10'd0, fpc, fifid, bub, flush, fpipe, mto}, 16'd0);
    chk("rst_state", {14'd0, st}, 16'd0);
    chk("rst_stall", scnt, 16'd0);
    chk("rst_flush", {8'd0, fcnt}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0; haz = 1'b0; br = 1'b0; mreq = 1'b0;
    es = '0; ef = '0;
  endtask
  initial begin
    @(posedge clk); #1;
    do_reset();
    step(0, 0, 0, 0, NONE, 0);
    step(1, 0, 0, 0, HAZ, 0);
    step(0, 0, 0, 0, NONE, 0);
    step(1, 1, 0, 0, BR, 0);
    step(0, 0, 0, 0, NONE, 0);
    step(0, 0, 1, 0, FRZ, 0);
    step(1, 0, 1, 0, FRZ, 1);
    step(0, 1, 1, 0, FRZ, 1);
    step(0, 0, 1, 1, NONE, 1);
    step(0, 0, 0, 0, NONE, 0);
    step(1, 0, 1, 1, HAZ, 0);
    step(0, 1, 1, 0, FRZ, 0);
    step(0, 1, 0, 0, FRZ, 1);
    step(0, 1, 0, 1, BR, 1);
    step(0, 0, 0, 0, NONE, 0);
    step(0, 0, 1, 0, FRZ, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, FRZ, 1);
    step(1, 1, 1, 1, TO, 2);
    step(0, 0, 0, 1, TO, 2);
    step(0, 0, 0, 0, TO, 2);
    do_reset();
    step(0, 0, 0, 0, NONE, 0);
    step(0, 0, 1, 0, FRZ, 0);
    step(0, 0, 0, 0, FRZ, 1);
    do_reset();
    step(0, 0, 0, 0, NONE, 0);
    for (int i = 0; i < 300; i++) step(0, 1, 0, 0, BR, 0);
    step(0, 0, 0, 0, NONE, 0);
    chk("flush_sat", {8'd0, fcnt}, 16'd255);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, BR, 0);
    #2 rst = 1'b1;
    #1 chk("async_flush_clear", {8'd0, fcnt}, 16'd0);
    chk("async_stall_clear", scnt, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0; br = 1'b0; es = '0; ef = '0;
    step(0, 0, 0, 0, NONE, 0);
    step(1, 0, 0, 0, HAZ, 0);
    step(0, 0, 0, 0, NONE, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, sets the maximum number of MEM_WAIT cycles before a timeout (legal range 2..255).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 hazard_detected  input  1  RAW hazard flag from hazard detection logic, ID stage.
REQ-005 branch_taken  input  1  taken branch/jump resolved in EX.
REQ-006 mem_req  input  1  MEM-stage instruction is a load or store needing SRAM.
REQ-007 sram_ready  input  1  SRAM access completes this cycle.
REQ-008 freeze_PC  output  1  hold program counter.
REQ-009 freeze_IF_ID  output  1  hold IF/ID register.
REQ-010 bubble_ID_EX  output  1  load NOP into ID/EX register.
REQ-011 flush_IF_ID  output  1  clear IF/ID register.
REQ-012 freeze_pipe  output  1  hold every pipeline register and PC (memory stall).
REQ-013 mem_timeout  output  1  sticky SRAM timeout error.
REQ-014 state  output  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 TIMEOUT.
REQ-015 stall_count  output  16  saturating count of stall cycles.
REQ-016 flush_count  output  8  saturating count of branch flushes.

Function
REQ-017 Control outputs are combinational (Mealy) from state and inputs; counters, state and wait counter are registered.
REQ-018 Stall/flush decision priority: freeze_pipe > branch flush > hazard stall.
REQ-019 RUN, mem_req=1 and sram_ready=0: freeze_pipe=1 same cycle, next state MEM_WAIT, wait counter loaded with 1.
REQ-020 RUN, mem_req=0 or sram_ready=1: freeze_pipe=0 and the branch/hazard rules below apply; state stays RUN.
REQ-021 Branch rule (freeze_pipe=0, branch_taken=1): flush_IF_ID=1, bubble_ID_EX=1, freeze_PC=0, freeze_IF_ID=0; hazard_detected ignored.
REQ-022 Hazard rule (freeze_pipe=0, branch_taken=0, hazard_detected=1): freeze_PC=1, freeze_IF_ID=1, bubble_ID_EX=1, flush_IF_ID=0.
REQ-023 While freeze_pipe=1, freeze_PC=1, freeze_IF_ID=1, bubble_ID_EX=0 and flush_IF_ID=0, regardless of branch_taken or hazard_detected.
REQ-024 MEM_WAIT, sram_ready=1: freeze_pipe=0 that cycle, branch/hazard rules apply, next state RUN, wait counter cleared.
REQ-025 MEM_WAIT, sram_ready=0, wait counter < MEM_TIMEOUT: freeze_pipe=1, wait counter increments by 1.
REQ-026 MEM_WAIT, sram_ready=0, wait counter = MEM_TIMEOUT: freeze_pipe=1, next state TIMEOUT.
REQ-027 TIMEOUT: freeze_pipe=1 and mem_timeout=1 permanently; exit only by rst; sram_ready ignored.
REQ-028 mem_req is sampled only in RUN; a mem_req drop during MEM_WAIT does not end the wait.
REQ-029 stall_count increments by 1 on every cycle with freeze_pipe=1 or freeze_PC=1, saturating at 16'hFFFF.
REQ-030 flush_count increments by 1 on every cycle with flush_IF_ID=1, saturating at 8'hFF.
REQ-031 State encoding 3 is unreachable and SHALL behave as RUN, then transition as from RUN.

Reset
REQ-032 rst=1 asynchronously forces state=RUN, wait counter=0, stall_count=0, flush_count=0, mem_timeout=0.
REQ-033 With rst=1 all control outputs SHALL be 0, independent of inputs.
REQ-034 rst asserted mid MEM_WAIT or TIMEOUT returns to RUN with no residual freeze on the first cycle after release.

Verification
REQ-035 RUN, hazard_detected=1 for 1 cycle -> freeze_PC=freeze_IF_ID=bubble_ID_EX=1 that cycle, stall_count=1 after.
REQ-036 hazard_detected=1 and branch_taken=1 same cycle -> flush_IF_ID=bubble_ID_EX=1, freeze_PC=0, flush_count=1, stall_count=0.
REQ-037 mem_req=1, sram_ready low for 3 cycles then high -> freeze_pipe=1 for 3 cycles, 0 on the ready cycle, state back to RUN, stall_count=3.
REQ-038 MEM_TIMEOUT=4, mem_req=1, sram_ready held 0 -> state=TIMEOUT after 5 cycles, mem_timeout=1 and freeze_pipe=1 persist until rst.
REQ-039 branch_taken=1 during MEM_WAIT -> flush_IF_ID=0, flush_count unchanged.
REQ-040 300 consecutive branch cycles -> flush_count saturates at 255; rst mid-sequence clears it to 0 asynchronously.
